// File: rtl/sched_pkg.sv
// Shared types and defaults for the round-robin process scheduler.
package sched_pkg;

  localparam int NUM_PROC    = 4;
  localparam int PC_W        = 10;
  localparam int OFF_W       = 8;
  localparam int DEF_QUANTUM = 16;
  localparam int ID_W        = $clog2(NUM_PROC);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_SAVE,
    ST_SELECT,
    ST_RESTORE,
    ST_HALTED
  } state_e;

  typedef struct packed {
    logic             active;
    logic [PC_W-1:0]  pc;
    logic [OFF_W-1:0] offset;
  } entry_t;

endpackage

// File: rtl/process_scheduler_if.sv
// Control-unit side of the scheduler: retire/end/halt decodes, table loads and the PC/offset reload path.
interface process_scheduler_if;
  import sched_pkg::*;

  logic             instr_retire;
  logic             end_of_process;
  logic             halt_in;
  logic             load_valid;
  logic [ID_W-1:0]  load_id;
  logic [PC_W-1:0]  load_pc;
  logic [OFF_W-1:0] load_offset;
  logic [PC_W-1:0]  cur_pc;

  logic             stall;
  logic             pc_load;
  logic [PC_W-1:0]  pc_next;
  logic             offset_load;
  logic [OFF_W-1:0] offset_out;
  logic [ID_W-1:0]  cur_id;
  logic             idle;
  logic             halted;
  logic             load_err;

  // Strobes and inputs are single-cycle qualifiers sampled on the rising edge; there is no back-pressure.
  modport master (
    output instr_retire, end_of_process, halt_in, load_valid, load_id, load_pc, load_offset, cur_pc,
    input  stall, pc_load, pc_next, offset_load, offset_out, cur_id, idle, halted, load_err
  );

  modport slave (
    input  instr_retire, end_of_process, halt_in, load_valid, load_id, load_pc, load_offset, cur_pc,
    output stall, pc_load, pc_next, offset_load, offset_out, cur_id, idle, halted, load_err
  );

endinterface

// File: rtl/rr_select.sv
// Combinational round-robin finder: first set bit of active at or after start, wrapping.
module rr_select #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  active,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] index
);

  logic [IW-1:0] idx;

  // N is a power of two, so the IW-bit add wraps modulo N for free.
  always_comb begin
    found = 1'b0;
    index = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = start + IW'(i);
      if (!found && active[idx]) begin
        found = 1'b1;
        index = idx;
      end
    end
  end

endmodule

// File: rtl/process_scheduler.sv
// Preemptive round-robin scheduler: counts retired instructions per slice and sequences
// SAVE -> SELECT -> RESTORE context switches over a small process table.
module process_scheduler
  import sched_pkg::*;
#(
  parameter int QUANTUM = DEF_QUANTUM
) (
  input  logic                clock,
  input  logic                reset_n,
  process_scheduler_if.slave  bus,
  output state_e              dbg_state
);

  localparam int              CNT_W    = $clog2(QUANTUM + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);

  state_e                     state_q, state_d;
  entry_t [NUM_PROC-1:0]      table_q, table_d;
  logic   [ID_W-1:0]          cur_id_q, cur_id_d;
  logic   [CNT_W-1:0]         cnt_q, cnt_d;
  logic                       ending_q, ending_d;
  logic                       load_err_q, load_err_d;

  logic   [NUM_PROC-1:0]      active_vec;
  logic   [ID_W-1:0]          start_idx;
  logic                       sel_found;
  logic   [ID_W-1:0]          sel_idx;
  logic                       load_reject;
  logic                       restore;

  always_comb begin
    active_vec = '0;
    for (int i = 0; i < NUM_PROC; i++) active_vec[i] = table_q[i].active;
  end

  assign start_idx = cur_id_q + ID_W'(1);

  rr_select #(.N(NUM_PROC), .IW(ID_W)) u_rr_select (
    .active (active_vec),
    .start  (start_idx),
    .found  (sel_found),
    .index  (sel_idx)
  );

  always_comb begin
    state_d     = state_q;
    table_d     = table_q;
    cur_id_d    = cur_id_q;
    cnt_d       = cnt_q;
    ending_d    = ending_q;
    load_err_d  = 1'b0;
    load_reject = bus.load_valid && (bus.load_id == cur_id_q) &&
                  (state_q inside {ST_RUN, ST_SAVE, ST_RESTORE});

    case (state_q)
      ST_IDLE: if (|active_vec) state_d = ST_SELECT;
      ST_RUN: begin
        if (bus.instr_retire) cnt_d = cnt_q + CNT_W'(1);
        if (bus.end_of_process || (bus.instr_retire && cnt_q == CNT_LAST)) begin
          state_d  = ST_SAVE;
          ending_d = bus.end_of_process;
        end
      end
      ST_SAVE: begin
        // A finished process is retired rather than saved, so its PC is never written back.
        if (ending_q) table_d[cur_id_q].active = 1'b0;
        else          table_d[cur_id_q].pc     = bus.cur_pc;
        state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (sel_found) begin
          cur_id_d = sel_idx;
          state_d  = ST_RESTORE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESTORE: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase

    if (bus.load_valid && state_q != ST_HALTED) begin
      if (load_reject) load_err_d = 1'b1;
      else table_d[bus.load_id] = '{active: 1'b1, pc: bus.load_pc, offset: bus.load_offset};
    end

    // Halt freezes everything else decided this cycle.
    if (bus.halt_in) begin
      state_d    = ST_HALTED;
      table_d    = table_q;
      cur_id_d   = cur_id_q;
      cnt_d      = cnt_q;
      ending_d   = ending_q;
      load_err_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      table_q    <= '0;
      cur_id_q   <= '0;
      cnt_q      <= '0;
      ending_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      table_q    <= table_d;
      cur_id_q   <= cur_id_d;
      cnt_q      <= cnt_d;
      ending_q   <= ending_d;
      load_err_q <= load_err_d;
    end
  end

  assign restore         = (state_q == ST_RESTORE);
  assign bus.stall       = state_q inside {ST_SAVE, ST_SELECT, ST_RESTORE, ST_HALTED};
  assign bus.pc_load     = restore;
  assign bus.offset_load = restore;
  assign bus.pc_next     = restore ? table_q[cur_id_q].pc     : '0;
  assign bus.offset_out  = restore ? table_q[cur_id_q].offset : '0;
  assign bus.cur_id      = cur_id_q;
  assign bus.idle        = (state_q == ST_IDLE);
  assign bus.halted      = (state_q == ST_HALTED);
  assign bus.load_err    = load_err_q;
  assign dbg_state       = state_q;

endmodule
